// File: rtl/dsp_equation_dispatch_pkg.sv
// Types and constants shared by the equation dispatcher and its watchdog.
// Status values match the B_DSP_STATUS_* encodings in dsp_includes.vh.
package dsp_equation_dispatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam logic [2:0] STAT_NONE    = 3'd0;
   localparam logic [2:0] STAT_OK      = 3'd1;
   localparam logic [2:0] STAT_BAD_EQ  = 3'd2;
   localparam logic [2:0] STAT_TIMEOUT = 3'd3;
   localparam logic [2:0] STAT_ENG_ERR = 3'd4;
   localparam logic [2:0] STAT_ABORT   = 3'd5;

   localparam int FNW = 8;

endpackage

// File: rtl/dsp_dispatch_watchdog.sv
// Saturating run-length counter; expired flags the cycle in which the run
// reaches its limit-th cycle. A zero limit never expires.
module dsp_dispatch_watchdog #(
   parameter int TW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          enable,
   input  logic [TW-1:0] limit,
   output logic          expired
);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && (cnt != {TW{1'b1}})) begin
         cnt <= cnt + TW'(1);
      end
   end

   // cnt holds the number of RUN cycles already completed
   assign expired = enable && (limit != '0) && (cnt == limit - TW'(1));

endmodule

// File: rtl/dsp_includes.vh
// Shared DSP slave status encodings and the status field position in the
// slave status register.
`ifndef DSP_INCLUDES_VH
`define DSP_INCLUDES_VH

`define B_DSP_STATUS_NONE    3'd0
`define B_DSP_STATUS_OK      3'd1
`define B_DSP_STATUS_BAD_EQ  3'd2
`define B_DSP_STATUS_TIMEOUT 3'd3
`define B_DSP_STATUS_ENG_ERR 3'd4
`define B_DSP_STATUS_ABORT   3'd5

`define F_DSP_SLAVE_STATUS   2:0

`endif

// File: rtl/dsp_equation_dispatch.sv
// Dispatcher between the DSP slave registers and NUM_EQ equation engines:
// one-hot engine enable, locked selection, file-port routing and status.
module dsp_equation_dispatch
   import dsp_equation_dispatch_pkg::*;
#(
   parameter int NUM_EQ = 4,
   parameter int EQW    = 8,
   parameter int DW     = 32,
   parameter int TW     = 16
) (
   input  logic                  wb_clk,
   input  logic                  wb_rst_n,
   input  logic                  start,
   input  logic [EQW-1:0]        eq_num,
   input  logic [TW-1:0]         timeout_limit,
   input  logic                  abort,
   output logic [NUM_EQ-1:0]     eng_enable,
   input  logic [NUM_EQ-1:0]     eng_done,
   input  logic [NUM_EQ-1:0]     eng_error,
   input  logic [NUM_EQ*8-1:0]   eng_file_num,
   input  logic [NUM_EQ-1:0]     eng_file_write,
   input  logic [NUM_EQ-1:0]     eng_file_read,
   input  logic [NUM_EQ*DW-1:0]  eng_file_write_data,
   output logic [7:0]            file_num,
   output logic                  file_write,
   output logic                  file_read,
   output logic [DW-1:0]         file_write_data,
   output logic                  busy,
   output logic                  done,
   output logic                  interrupt,
   output logic [2:0]            status,
   output logic [EQW-1:0]        active_eq
);

   state_t          state, state_nxt;
   logic [2:0]      status_nxt;
   logic [TW-1:0]   limit;
   logic            accept;
   logic            eq_ok;
   logic            sel_done;
   logic            sel_err;
   logic            wd_expired;

   assign accept = (state == ST_IDLE) && start;
   assign eq_ok  = (32'(eq_num) < NUM_EQ);

   // Selection is only honoured in RUN, so enables and file outputs fall to
   // zero as soon as the state register leaves RUN (including on reset).
   always_comb begin
      eng_enable      = '0;
      sel_done        = 1'b0;
      sel_err         = 1'b0;
      file_num        = '0;
      file_write      = 1'b0;
      file_read       = 1'b0;
      file_write_data = '0;
      if (state == ST_RUN) begin
         for (int i = 0; i < NUM_EQ; i++) begin
            if (active_eq == EQW'(i)) begin
               eng_enable[i]   = 1'b1;
               sel_done        = eng_done[i];
               sel_err         = eng_error[i];
               file_num        = eng_file_num[FNW*i +: FNW];
               file_write      = eng_file_write[i];
               file_read       = eng_file_read[i];
               file_write_data = eng_file_write_data[DW*i +: DW];
            end
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      status_nxt = status;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (eq_ok) begin
                  state_nxt  = ST_RUN;
                  status_nxt = STAT_NONE;
               end else begin
                  state_nxt  = ST_FINISH;
                  status_nxt = STAT_BAD_EQ;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_nxt  = ST_FINISH;
               status_nxt = STAT_ABORT;
            end else if (sel_err) begin
               state_nxt  = ST_FINISH;
               status_nxt = STAT_ENG_ERR;
            end else if (sel_done) begin
               state_nxt  = ST_FINISH;
               status_nxt = STAT_OK;
            end else if (wd_expired) begin
               state_nxt  = ST_FINISH;
               status_nxt = STAT_TIMEOUT;
            end
         end
         ST_FINISH: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state     <= ST_IDLE;
         status    <= STAT_NONE;
         active_eq <= '0;
         limit     <= '0;
      end else begin
         state  <= state_nxt;
         status <= status_nxt;
         if (accept) begin
            active_eq <= eq_num;
            if (eq_ok) limit <= timeout_limit;
         end
      end
   end

   dsp_dispatch_watchdog #(.TW(TW)) u_watchdog (
      .clk     (wb_clk),
      .rst_n   (wb_rst_n),
      .clear   (accept),
      .enable  (state == ST_RUN),
      .limit   (limit),
      .expired (wd_expired)
   );

   assign busy      = (state == ST_RUN);
   assign done      = (state == ST_FINISH);
   assign interrupt = (state == ST_FINISH);

endmodule

// File: tb/tb_dsp_equation_dispatch.sv
// Bench for dsp_equation_dispatch: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a run-level model.
module tb_dsp_equation_dispatch;

   localparam int NUM_EQ = 4;
   localparam int EQW    = 8;
   localparam int DW     = 32;
   localparam int TW     = 16;

   logic                 wb_clk = 1'b0;
   logic                 wb_rst_n = 1'b0;
   logic                 start = 1'b0;
   logic [EQW-1:0]       eq_num = '0;
   logic [TW-1:0]        timeout_limit = '0;
   logic                 abort = 1'b0;
   logic [NUM_EQ-1:0]    eng_enable;
   logic [NUM_EQ-1:0]    eng_done = '0;
   logic [NUM_EQ-1:0]    eng_error = '0;
   logic [NUM_EQ*8-1:0]  eng_file_num = '0;
   logic [NUM_EQ-1:0]    eng_file_write = '0;
   logic [NUM_EQ-1:0]    eng_file_read = '0;
   logic [NUM_EQ*DW-1:0] eng_file_write_data = '0;
   logic [7:0]           file_num;
   logic                 file_write;
   logic                 file_read;
   logic [DW-1:0]        file_write_data;
   logic                 busy, done, interrupt;
   logic [2:0]           status;
   logic [EQW-1:0]       active_eq;

   always #5 wb_clk = ~wb_clk;

   dsp_equation_dispatch #(.NUM_EQ(NUM_EQ), .EQW(EQW), .DW(DW), .TW(TW)) dut (
      .wb_clk              (wb_clk),
      .wb_rst_n            (wb_rst_n),
      .start               (start),
      .eq_num              (eq_num),
      .timeout_limit       (timeout_limit),
      .abort               (abort),
      .eng_enable          (eng_enable),
      .eng_done            (eng_done),
      .eng_error           (eng_error),
      .eng_file_num        (eng_file_num),
      .eng_file_write      (eng_file_write),
      .eng_file_read       (eng_file_read),
      .eng_file_write_data (eng_file_write_data),
      .file_num            (file_num),
      .file_write          (file_write),
      .file_read           (file_read),
      .file_write_data     (file_write_data),
      .busy                (busy),
      .done                (done),
      .interrupt           (interrupt),
      .status              (status),
      .active_eq           (active_eq)
   );

   int n_chk  = 0;
   int n_pass = 0;
   bit rand_files = 1'b1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Run-level model: a run is either in progress (m_run), being reported
   // (m_fin) or absent; m_cyc counts RUN cycles already elapsed.
   bit         m_run, m_fin;
   logic [7:0] m_eq;
   int         m_lim, m_cyc;
   logic [2:0] m_status;

   always @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         m_run <= 0; m_fin <= 0; m_eq <= '0; m_lim <= 0; m_cyc <= 0; m_status <= 3'd0;
      end else if (m_fin) begin
         m_fin <= 0;
      end else if (m_run) begin
         m_cyc <= m_cyc + 1;
         if (abort) begin
            m_run <= 0; m_fin <= 1; m_status <= 3'd5;
         end else if (eng_error[m_eq]) begin
            m_run <= 0; m_fin <= 1; m_status <= 3'd4;
         end else if (eng_done[m_eq]) begin
            m_run <= 0; m_fin <= 1; m_status <= 3'd1;
         end else if (m_lim != 0 && m_cyc + 1 == m_lim) begin
            m_run <= 0; m_fin <= 1; m_status <= 3'd3;
         end
      end else if (start) begin
         m_eq <= eq_num;
         if (int'(eq_num) < NUM_EQ) begin
            m_run <= 1; m_lim <= int'(timeout_limit); m_cyc <= 0; m_status <= 3'd0;
         end else begin
            m_fin <= 1; m_status <= 3'd2;
         end
      end
   end

   always @(negedge wb_clk) begin
      if (wb_rst_n) begin
         logic [NUM_EQ-1:0] e_en;
         logic [7:0]        e_fn;
         logic              e_fw, e_fr;
         logic [DW-1:0]     e_fd;
         e_en = '0; e_fn = '0; e_fw = 0; e_fr = 0; e_fd = '0;
         if (m_run) begin
            e_en[m_eq] = 1'b1;
            e_fn = eng_file_num[8*m_eq +: 8];
            e_fw = eng_file_write[m_eq];
            e_fr = eng_file_read[m_eq];
            e_fd = eng_file_write_data[DW*m_eq +: DW];
         end
         check("cycle",
               {eng_enable, busy, done, interrupt, status, active_eq, file_num, file_write, file_read, file_write_data},
               {e_en, m_run, m_fin, m_fin, m_status, m_eq, e_fn, e_fw, e_fr, e_fd});
      end
   end

   task automatic tick();
      @(posedge wb_clk);
      #1;
      if (rand_files) begin
         eng_file_num        = $urandom;
         eng_file_write      = NUM_EQ'($urandom_range(0, 15));
         eng_file_read       = NUM_EQ'($urandom_range(0, 15));
         eng_file_write_data = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic launch(input logic [7:0] eq, input logic [15:0] lim);
      start = 1; eq_num = eq; timeout_limit = lim;
      tick();
      start = 0;
   endtask

   initial begin
      int n;
      #12;
      check("reset_outputs", {eng_enable, busy, done, interrupt, status, active_eq, file_num, file_write, file_read},
            '0);
      wb_rst_n = 1;
      tick();

      // normal completion on engine 2 after 10 RUN cycles
      launch(8'd2, 16'd0);
      for (int k = 1; k <= 10; k++) begin
         check("t1_enable", eng_enable, 4'b0100);
         if (k == 10) eng_done = 4'b0100;
         tick();
      end
      eng_done = '0;
      check("t1_finish", {eng_enable, busy, done, interrupt, status}, {4'b0000, 1'b0, 1'b1, 1'b1, 3'd1});
      tick();
      check("t1_after", {done, interrupt, status}, {1'b0, 1'b0, 3'd1});

      // out-of-range equation
      launch(8'd7, 16'd0);
      check("t2_bad_eq", {eng_enable, busy, done, status, active_eq}, {4'b0000, 1'b0, 1'b1, 3'd2, 8'd7});
      tick();

      // watchdog with limit 5
      launch(8'd1, 16'd5);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (!eng_enable[1]) break;
         n++;
         tick();
      end
      check("t3_enable_cycles", n, 5);
      check("t3_timeout", {done, status}, {1'b1, 3'd3});
      tick();

      // abort beats done in the same cycle
      launch(8'd1, 16'd0);
      tick(); tick();
      eng_done = 4'b0010; abort = 1;
      tick();
      eng_done = '0; abort = 0;
      check("t4_abort", {done, status}, {1'b1, 3'd5});
      tick();

      // mid-run start and stray done from another engine are ignored
      launch(8'd3, 16'd0);
      tick();
      start = 1; eq_num = 8'd0; eng_done = 4'b0001;
      tick();
      start = 0; eng_done = '0;
      check("t5_locked", {active_eq, eng_enable, busy, status}, {8'd3, 4'b1000, 1'b1, 3'd0});
      eng_done = 4'b1000;
      tick();
      eng_done = '0;
      check("t5_done", {active_eq, status, done}, {8'd3, 3'd1, 1'b1});
      tick();

      // file routing passthrough and idle blanking
      rand_files = 0;
      launch(8'd1, 16'd0);
      eng_file_num        = 32'hAABB12CC;
      eng_file_write      = 4'b0010;
      eng_file_read       = 4'b1101;
      eng_file_write_data = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
      #1;
      check("t6_route", {file_num, file_write, file_read, file_write_data}, {8'h12, 1'b1, 1'b0, 32'hDEADBEEF});
      eng_done = 4'b0010;
      tick();
      eng_done = '0;
      tick();
      check("t6_idle_blank", {busy, file_num, file_write, file_read, file_write_data}, '0);
      rand_files = 1;

      // asynchronous reset mid-run
      launch(8'd2, 16'd0);
      tick();
      wb_rst_n = 0;
      #1;
      check("t7_async_drop", {eng_enable, busy}, '0);
      #1;
      wb_rst_n = 1;
      tick();
      check("t7_after_reset", {status, eng_enable, busy, active_eq}, '0);

      // randomized traffic, compared every cycle against the model
      for (int it = 0; it < 1500; it++) begin
         start         = ($urandom_range(0, 3) == 0);
         eq_num        = 8'($urandom_range(0, 5));
         timeout_limit = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
         abort         = ($urandom_range(0, 29) == 0);
         for (int i = 0; i < NUM_EQ; i++) begin
            eng_done[i]  = ($urandom_range(0, 9) == 0);
            eng_error[i] = ($urandom_range(0, 39) == 0);
         end
         tick();
      end
      start = 0; abort = 0; eng_done = '0; eng_error = '0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
